// File: rtl/filt_tx_sequencer_pkg.sv
// rtl/filt_tx_sequencer_pkg.sv - shared state type, symbol levels and PRBS constants
// Package tx_seq_pkg: burst state enum, 1s17 output levels, PRBS15 seed/taps
// and the Gray map from a PRBS bit pair to an output level.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PRE,
        ST_DATA,
        ST_FLUSH,
        ST_DONE
    } tx_state_t;

    localparam int LVL_OUTER   = 98303;
    localparam int LVL_INNER   = 32768;
    localparam int LVL_IMPULSE = 131071;

    // x^15 + x^14 + 1: feedback taps are state bits 14 and 13
    localparam logic [14:0] PRBS_SEED   = 15'h7FFF;
    localparam int          PRBS_TAP_HI = 14;
    localparam int          PRBS_TAP_LO = 13;

    function automatic int gray_level(input logic [1:0] bits);
        int lvl;
        unique case (bits)
            2'b00:   lvl = -LVL_OUTER;
            2'b01:   lvl = -LVL_INNER;
            2'b11:   lvl = LVL_INNER;
            default: lvl = LVL_OUTER;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/filt_tx_sequencer_if.sv
// rtl/filt_tx_sequencer_if.sv - control and sample bus between clk_en/host and the sequencer
// Signals: sam_clk_en, sym_clk_en (time base), start, abort, num_sym (burst
// request), busy, done, filt_clr (status), x_out, sym_strobe (sample stream).
// TX_SEQ_IMPULSE_EN adds the impulse request bit.
// master: drives time base and requests; slave: the sequencer.
interface filt_tx_sequencer_if #(
    parameter int WIDTH = 18
);
    logic                    sam_clk_en;
    logic                    sym_clk_en;
    logic                    start;
    logic                    abort;
    logic [15:0]             num_sym;
    logic                    busy;
    logic                    done;
    logic                    filt_clr;
    logic signed [WIDTH-1:0] x_out;
    logic                    sym_strobe;
`ifdef TX_SEQ_IMPULSE_EN
    logic                    impulse;

    modport master (
        output sam_clk_en, sym_clk_en, start, abort, num_sym, impulse,
        input  busy, done, filt_clr, x_out, sym_strobe
    );
    modport slave (
        input  sam_clk_en, sym_clk_en, start, abort, num_sym, impulse,
        output busy, done, filt_clr, x_out, sym_strobe
    );
`else
    modport master (
        output sam_clk_en, sym_clk_en, start, abort, num_sym,
        input  busy, done, filt_clr, x_out, sym_strobe
    );
    modport slave (
        input  sam_clk_en, sym_clk_en, start, abort, num_sym,
        output busy, done, filt_clr, x_out, sym_strobe
    );
`endif
endinterface

// File: rtl/filt_tx_sequencer_prbs15.sv
// rtl/filt_tx_sequencer_prbs15.sv - PRBS15 source producing two bits per advance
// Ports: clk, reset (sync, active-high), advance (step two bits), reseed
// (reload seed), sym[1:0] (next pair; sym[1] is the earlier bit).
module prbs15
    import tx_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       reseed,
    output logic [1:0] sym
);

    logic [14:0] lfsr_q;
    logic        fb_first;
    logic        fb_second;

    // Two serial steps unrolled: the second feedback uses the taps shifted down
    // by one, which are still untouched by the first step's shift-in.
    assign fb_first  = lfsr_q[PRBS_TAP_HI] ^ lfsr_q[PRBS_TAP_LO];
    assign fb_second = lfsr_q[PRBS_TAP_HI - 1] ^ lfsr_q[PRBS_TAP_LO - 1];
    assign sym       = {fb_first, fb_second};

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= PRBS_SEED;
        end else if (reseed) begin
            lfsr_q <= PRBS_SEED;
        end else if (advance) begin
            lfsr_q <= {lfsr_q[12:0], fb_first, fb_second};
        end
    end

endmodule

// File: rtl/filt_tx_sequencer.sv
// rtl/filt_tx_sequencer.sv - burst sequencer: preamble, PRBS 4-ASK data, zero flush
// Ports: sys_clk, reset (sync, active-high), bus (filt_tx_sequencer_if.slave):
// time-base enables and start/abort/num_sym in; busy, done, filt_clr,
// x_out and sym_strobe out.
// Option macro TX_SEQ_IMPULSE_EN: impulse request replaces preamble and data
// with a single full-scale sample.
module filt_tx_sequencer
    import tx_seq_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int SPS       = 4,
    parameter int PRE_LEN   = 16,
    parameter int FLUSH_LEN = 101
) (
    input  logic             sys_clk,
    input  logic             reset,
    filt_tx_sequencer_if.slave bus
);

    // Flush entry may already count its first sample, so FLUSH_LEN >= 2.
    if (SPS < 2 || PRE_LEN < 1 || FLUSH_LEN < 2) begin : g_param_check
        $error("filt_tx_sequencer: SPS >= 2, PRE_LEN >= 1, FLUSH_LEN >= 2 required");
    end

    tx_state_t               state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             num_q, num_d;
    logic [15:0]             eff_num;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] pre_val;
    logic signed [WIDTH-1:0] data_val;
    logic                    strobe_q, strobe_d;
    logic                    clr_q, clr_d;
    logic                    go_flush;
    logic                    emit_data;
    logic                    prbs_reseed;
    logic                    prbs_advance;
    logic [1:0]              prbs_sym;
    logic                    imp_mode;

`ifdef TX_SEQ_IMPULSE_EN
    logic imp_q, imp_d;
    assign imp_mode = imp_q;
`else
    assign imp_mode = 1'b0;
`endif

    prbs15 u_prbs (
        .clk     (sys_clk),
        .reset   (reset),
        .advance (prbs_advance),
        .reseed  (prbs_reseed),
        .sym     (prbs_sym)
    );

    // In PRE/ARM cnt_q is the number of preamble symbols already sent, so its
    // LSB selects the alternating polarity (even index -> positive).
    assign pre_val  = cnt_q[0] ? WIDTH'(-LVL_OUTER) : WIDTH'(LVL_OUTER);
    assign data_val = imp_mode ? WIDTH'(LVL_IMPULSE) : WIDTH'(gray_level(prbs_sym));
    assign eff_num  = imp_mode ? 16'd1 : num_q;

    assign prbs_advance = emit_data & ~imp_mode;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            x_q      <= '0;
            strobe_q <= 1'b0;
            clr_q    <= 1'b0;
`ifdef TX_SEQ_IMPULSE_EN
            imp_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            x_q      <= x_d;
            strobe_q <= strobe_d;
            clr_q    <= clr_d;
`ifdef TX_SEQ_IMPULSE_EN
            imp_q    <= imp_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        x_d         = x_q;
        strobe_d    = 1'b0;
        clr_d       = 1'b0;
        prbs_reseed = 1'b0;
        go_flush    = 1'b0;
        emit_data   = 1'b0;
`ifdef TX_SEQ_IMPULSE_EN
        imp_d       = imp_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_ARM;
                    cnt_d       = '0;
                    num_d       = bus.num_sym;
                    clr_d       = 1'b1;
                    prbs_reseed = 1'b1;
`ifdef TX_SEQ_IMPULSE_EN
                    imp_d       = bus.impulse;
`endif
                end
            end
            ST_ARM: begin
                if (bus.abort) begin
                    go_flush = 1'b1;
                end else if (bus.sym_clk_en) begin
                    cnt_d = 16'd1;
                    if (imp_mode) begin
                        emit_data = 1'b1;
                    end else begin
                        state_d  = ST_PRE;
                        x_d      = pre_val;
                        strobe_d = 1'b1;
                    end
                end else if (bus.sam_clk_en) begin
                    x_d = '0;
                end
            end
            ST_PRE: begin
                if (bus.abort) begin
                    go_flush = 1'b1;
                end else if (bus.sym_clk_en) begin
                    // Phase changes only on a symbol boundary so the last
                    // preamble symbol keeps its full set of stuffing zeros.
                    if (cnt_q == 16'(PRE_LEN)) begin
                        if (eff_num == 16'd0) begin
                            go_flush = 1'b1;
                        end else begin
                            emit_data = 1'b1;
                            cnt_d     = 16'd1;
                        end
                    end else begin
                        x_d      = pre_val;
                        strobe_d = 1'b1;
                        cnt_d    = cnt_q + 16'd1;
                    end
                end else if (bus.sam_clk_en) begin
                    x_d = '0;
                end
            end
            ST_DATA: begin
                if (bus.abort) begin
                    go_flush = 1'b1;
                end else if (bus.sym_clk_en) begin
                    if (cnt_q == eff_num) begin
                        go_flush = 1'b1;
                    end else begin
                        emit_data = 1'b1;
                        cnt_d     = cnt_q + 16'd1;
                    end
                end else if (bus.sam_clk_en) begin
                    x_d = '0;
                end
            end
            ST_FLUSH: begin
                if (bus.sam_clk_en) begin
                    x_d = '0;
                    if (cnt_q == 16'(FLUSH_LEN - 1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit_data) begin
            state_d  = ST_DATA;
            x_d      = data_val;
            strobe_d = 1'b1;
        end

        // A flush entered on a sample cycle already emits its first zero.
        if (go_flush) begin
            state_d = ST_FLUSH;
            cnt_d   = bus.sam_clk_en ? 16'd1 : 16'd0;
            if (bus.sam_clk_en) begin
                x_d = '0;
            end
        end
    end

    assign bus.x_out      = x_q;
    assign bus.sym_strobe = strobe_q;
    assign bus.filt_clr   = clr_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.busy       = (state_q == ST_ARM) || (state_q == ST_PRE) ||
                            (state_q == ST_DATA) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_filt_tx_sequencer.sv
// tb/tb_filt_tx_sequencer.sv - directed self-checking bench for filt_tx_sequencer
module tb_filt_tx_sequencer;

    localparam int W     = 18;
    localparam int PRE   = 16;
    localparam int FLUSH = 101;

    logic sys_clk = 1'b0;
    logic reset;

    filt_tx_sequencer_if #(.WIDTH(W)) bus ();

    filt_tx_sequencer #(
        .WIDTH     (W),
        .SPS       (4),
        .PRE_LEN   (PRE),
        .FLUSH_LEN (FLUSH)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    int samp_q[$];
    int strb_q[$];
    int exp_data[64];
    int ph = 0;
    int busy_gaps;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Time base: a sample every 2 clocks, a symbol every 4 samples (ph == 0).
    initial begin
        bus.sam_clk_en = 1'b1;
        bus.sym_clk_en = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            ph = (ph + 1) % 8;
            bus.sam_clk_en = (ph % 2 == 0);
            bus.sym_clk_en = (ph == 0);
        end
    end

    function automatic int gray_ref(input int b1, input int b0);
        if (b1 == 0 && b0 == 0) return -98303;
        if (b1 == 0 && b0 == 1) return -32768;
        if (b1 == 1 && b0 == 1) return 32768;
        return 98303;
    endfunction

    // Serial PRBS15 reference, one bit per step, first bit of each pair is b1.
    task automatic build_ref();
        logic [14:0] m;
        logic        fb;
        int          b1, b0;
        m = 15'h7FFF;
        for (int k = 0; k < 64; k++) begin
            fb = m[14] ^ m[13]; m = {m[13:0], fb}; b1 = int'(fb);
            fb = m[14] ^ m[13]; m = {m[13:0], fb}; b0 = int'(fb);
            exp_data[k] = gray_ref(b1, b0);
        end
    endtask

    // Start is placed on a symbol-enable cycle so that enable must be skipped.
    task automatic issue_start(input int nsym);
        int guard;
        guard = 0;
        @(negedge sys_clk);
        while (ph != 0 && guard < 16) begin
            @(negedge sys_clk);
            guard++;
        end
        check("start_align", int'(ph == 0), 1);
        bus.start   = 1'b1;
        bus.num_sym = nsym[15:0];
        @(negedge sys_clk);
        bus.start   = 1'b0;
        bus.num_sym = 16'd5;
        check("filt_clr_rise", int'(bus.filt_clr), 1);
        check("busy_rise", int'(bus.busy), 1);
    endtask

    task automatic run_burst(input int nsym, input int abort_at, input int busy_start_at,
                             input bit start_on_done);
        int cyc;
        int nstr;
        bit prev_sam, ab_clear, st_clear, fin, aborted;
        nstr = 0; ab_clear = 0; st_clear = 0; fin = 0; aborted = 0;
        samp_q.delete();
        strb_q.delete();
        busy_gaps = 0;
        issue_start(nsym);
        prev_sam = bus.sam_clk_en;
        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge sys_clk);
            if (cyc == 0) check("filt_clr_single", int'(bus.filt_clr), 0);
            if (ab_clear) begin bus.abort = 1'b0; ab_clear = 0; end
            if (st_clear) begin bus.start = 1'b0; bus.num_sym = 16'd5; st_clear = 0; end
            if (prev_sam) begin
                samp_q.push_back(int'(bus.x_out));
                strb_q.push_back(int'(bus.sym_strobe));
                if (bus.sym_strobe) nstr++;
            end
            if (bus.done) begin
                fin = 1;
                check("busy_low_on_done", int'(bus.busy), 0);
                if (start_on_done) begin
                    bus.start   = 1'b1;
                    bus.num_sym = 16'd2;
                end
            end else begin
                if (!bus.busy) busy_gaps++;
                if (abort_at > 0 && !aborted && bus.sym_strobe && nstr == abort_at) begin
                    bus.abort = 1'b1; aborted = 1; ab_clear = 1;
                end
                if (cyc == busy_start_at) begin
                    bus.start = 1'b1; bus.num_sym = 16'd3; st_clear = 1;
                end
            end
            prev_sam = bus.sam_clk_en;
        end
        check("burst_done_seen", int'(fin), 1);
        check("busy_steady", busy_gaps, 0);
        @(negedge sys_clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("done_one_cycle", int'(bus.done), 0);
        check("busy_after_done", int'(bus.busy), 0);
        @(negedge sys_clk);
        check("idle_after_done", int'(bus.busy), 0);
        check("no_clr_after_done", int'(bus.filt_clr), 0);
    endtask

    task automatic check_burst(input int nsym, input int abort_at);
        int f, emitted, expl, k, r, ev, es;
        f = -1;
        for (int i = 0; i < samp_q.size(); i++)
            if (strb_q[i] != 0 && f < 0) f = i;
        check("arm_zero_samples", f, 3);
        if (f < 0) f = 0;
        for (int i = 0; i < f; i++) check($sformatf("arm_x[%0d]", i), samp_q[i], 0);
        emitted = (abort_at > 0) ? abort_at : PRE + nsym;
        expl    = (abort_at > 0) ? (abort_at - 1) * 4 + 1 + FLUSH : (PRE + nsym) * 4 + FLUSH;
        check("burst_len", samp_q.size() - f, expl);
        for (int j = 0; j < samp_q.size() - f; j++) begin
            k = j / 4; r = j % 4; ev = 0; es = 0;
            if (r == 0 && k < emitted) begin
                es = 1;
                ev = (k < PRE) ? ((k % 2 == 0) ? 98303 : -98303) : exp_data[k - PRE];
            end
            check($sformatf("x_out[%0d]", j), samp_q[f + j], ev);
            check($sformatf("sym_strobe[%0d]", j), strb_q[f + j], es);
        end
    endtask

    initial begin
        int dn, guard, nstr_seen;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.num_sym = 16'd0;
`ifdef TX_SEQ_IMPULSE_EN
        bus.impulse = 1'b0;
`endif
        reset = 1'b1;
        build_ref();
        repeat (4) @(negedge sys_clk);
        check("rst_x_out", int'(bus.x_out), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_filt_clr", int'(bus.filt_clr), 0);
        check("rst_sym_strobe", int'(bus.sym_strobe), 0);
        reset = 1'b0;

        // Preamble only: 16*4 + 101 = 165 samples
        run_burst(0, 0, -1, 1'b0);
        check_burst(0, 0);

        // 8 data symbols: 197 samples; start while busy and on DONE ignored
        run_burst(8, 0, 60, 1'b1);
        check_burst(8, 0);

        // Long data run to cover every Gray level
        run_burst(64, 0, -1, 1'b0);
        check_burst(64, 0);

        // Abort right after data symbol 3 (strobe 19): 101 zeros then done
        run_burst(8, PRE + 3, -1, 1'b0);
        check_burst(8, PRE + 3);

        // Reset in the middle of FLUSH
        issue_start(0);
        repeat (200) @(negedge sys_clk);
        check("rst_flush_busy_before", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge sys_clk);
        check("rst_flush_x_out", int'(bus.x_out), 0);
        check("rst_flush_busy", int'(bus.busy), 0);
        check("rst_flush_done", int'(bus.done), 0);
        check("rst_flush_strobe", int'(bus.sym_strobe), 0);
        reset = 1'b0;
        dn = 0;
        repeat (400) begin
            @(negedge sys_clk);
            if (bus.done) dn++;
        end
        check("rst_flush_no_done", dn, 0);
        check("rst_flush_stays_idle", int'(bus.busy), 0);

        // Reset in the middle of PRE while x_out holds a negative symbol
        issue_start(0);
        guard = 0; nstr_seen = 0;
        while (nstr_seen < 2 && guard < 100) begin
            @(negedge sys_clk);
            if (bus.sym_strobe) nstr_seen++;
            guard++;
        end
        check("pre_second_symbol", int'(bus.x_out), -98303);
        reset = 1'b1;
        @(negedge sys_clk);
        check("rst_pre_x_out", int'(bus.x_out), 0);
        check("rst_pre_busy", int'(bus.busy), 0);
        check("rst_pre_strobe", int'(bus.sym_strobe), 0);
        reset = 1'b0;
        repeat (4) @(negedge sys_clk);

`ifdef TX_SEQ_IMPULSE_EN
        // Impulse: one +131071 sample, 101 zeros, done after 102 enables
        bus.impulse = 1'b1;
        run_burst(5, 0, -1, 1'b0);
        bus.impulse = 1'b0;
        begin
            int f;
            f = -1;
            for (int i = 0; i < samp_q.size(); i++)
                if (strb_q[i] != 0 && f < 0) f = i;
            check("imp_arm_zero_samples", f, 3);
            if (f < 0) f = 0;
            check("imp_len", samp_q.size() - f, 1 + FLUSH);
            check("imp_peak", samp_q[f], 131071);
            for (int j = 1; j < samp_q.size() - f; j++) begin
                check($sformatf("imp_x[%0d]", j), samp_q[f + j], 0);
                check($sformatf("imp_strobe[%0d]", j), strb_q[f + j], 0);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
